// File: rtl/demoman_pkg.sv
// Shared display constants and the colour type used by the sprite compositor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package demoman_pkg;

    typedef logic [7:0] color_t;

    localparam int     H_VISIBLE  = 640;
    localparam int     V_VISIBLE  = 480;
    localparam color_t BG_DEFAULT = 8'h00;

endpackage

// File: rtl/sprite_hit.sv
// Coverage test for one rectangular sprite against one pixel coordinate.
// Latency: purely combinational.
// Backpressure: none, evaluated every cycle.
module sprite_hit #(
    parameter int COORD_W  = 10,
    parameter int SPRITE_W = 10,
    parameter int SPRITE_H = 10
) (
    input  logic [COORD_W-1:0] sh_x_i,
    input  logic [COORD_W-1:0] sh_y_i,
    input  logic               sh_en_i,
    input  logic [COORD_W-1:0] pix_x_i,
    input  logic [COORD_W-1:0] pix_y_i,
    output logic               cover_o
);

    // One extra bit on the far edge so a sprite near the coordinate limit
    // extends past it instead of wrapping back to column/row zero.
    logic [COORD_W:0] x_end;
    logic [COORD_W:0] y_end;
    logic             in_x;
    logic             in_y;

    assign x_end = {1'b0, sh_x_i} + (COORD_W+1)'(SPRITE_W);
    assign y_end = {1'b0, sh_y_i} + (COORD_W+1)'(SPRITE_H);

    assign in_x = (pix_x_i >= sh_x_i) && ({1'b0, pix_x_i} < x_end);
    assign in_y = (pix_y_i >= sh_y_i) && ({1'b0, pix_y_i} < y_end);

    assign cover_o = sh_en_i && in_x && in_y;

endmodule

// File: rtl/sprite_layer.sv
// Multi-sprite compositor with end-of-frame shadow registers and frame tick.
// Latency: 2 cycles from pixel_x/pixel_y to color_out/hit_*/frame_tick.
// Backpressure: none, one pixel per clock. Optional SPRITE_LAYER_COLLIDE_EN adds collide_mask.
module sprite_layer
    import demoman_pkg::*;
#(
    parameter int                NUM_SPRITES = 2,
    parameter int                SPRITE_W    = 10,
    parameter int                SPRITE_H    = 10,
    parameter int                COORD_W     = 10,
    parameter int                COLOR_W     = $bits(color_t),
    parameter logic [COLOR_W-1:0] BG_COLOR   = BG_DEFAULT,
    parameter int                H_LAST      = H_VISIBLE - 1,
    parameter int                V_LAST      = V_VISIBLE - 1,
    localparam int               HIT_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [COORD_W-1:0]             pixel_x,
    input  logic [COORD_W-1:0]             pixel_y,
    input  logic [NUM_SPRITES*COORD_W-1:0] pos_x,
    input  logic [NUM_SPRITES*COORD_W-1:0] pos_y,
    input  logic [NUM_SPRITES*COLOR_W-1:0] sprite_color,
    input  logic [NUM_SPRITES-1:0]         sprite_en,
    output logic [COLOR_W-1:0]             color_out,
    output logic                           frame_tick,
    output logic [HIT_W-1:0]               hit_id,
    output logic                           hit_valid
`ifdef SPRITE_LAYER_COLLIDE_EN
    ,
    output logic [NUM_SPRITES-1:0]         collide_mask
`endif
);

    localparam logic [COORD_W-1:0] H_LAST_C = COORD_W'(H_LAST);
    localparam logic [COORD_W-1:0] V_LAST_C = COORD_W'(V_LAST);

    logic                           at_last;
    logic [NUM_SPRITES*COORD_W-1:0] sh_x_q;
    logic [NUM_SPRITES*COORD_W-1:0] sh_y_q;
    logic [NUM_SPRITES*COLOR_W-1:0] sh_color_q;
    logic [NUM_SPRITES-1:0]         sh_en_q;

    logic [NUM_SPRITES-1:0]         cover_d;
    logic [NUM_SPRITES-1:0]         cover_q;
    logic [NUM_SPRITES*COLOR_W-1:0] col1_q;
    logic                           last1_q;

    logic [COLOR_W-1:0]             color_d;
    logic [HIT_W-1:0]               hit_id_d;
    logic                           hit_vld_d;
    logic [COLOR_W-1:0]             color_q;
    logic [HIT_W-1:0]               hit_id_q;
    logic                           hit_vld_q;
    logic                           tick_q;

    assign at_last = (pixel_x == H_LAST_C) && (pixel_y == V_LAST_C);

    // Latch the game-logic sprite state only at the last visible pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_x_q     <= '0;
            sh_y_q     <= '0;
            sh_color_q <= '0;
            sh_en_q    <= '0;
        end else if (at_last) begin
            sh_x_q     <= pos_x;
            sh_y_q     <= pos_y;
            sh_color_q <= sprite_color;
            sh_en_q    <= sprite_en;
        end
    end

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_hit
        sprite_hit #(
            .COORD_W  (COORD_W),
            .SPRITE_W (SPRITE_W),
            .SPRITE_H (SPRITE_H)
        ) u_hit (
            .sh_x_i  (sh_x_q[i*COORD_W +: COORD_W]),
            .sh_y_i  (sh_y_q[i*COORD_W +: COORD_W]),
            .sh_en_i (sh_en_q[i]),
            .pix_x_i (pixel_x),
            .pix_y_i (pixel_y),
            .cover_o (cover_d[i])
        );
    end

    // Stage 1: coverage bits plus the colours that were live when they were
    // computed, so the last pixel of a frame still shows the old shadow colour.
    always_ff @(posedge clk) begin
        if (rst) begin
            cover_q <= '0;
            col1_q  <= '0;
            last1_q <= 1'b0;
        end else begin
            cover_q <= cover_d;
            col1_q  <= sh_color_q;
            last1_q <= at_last;
        end
    end

    // Priority encode: scan from the top so the lowest covering index wins.
    always_comb begin
        color_d   = BG_COLOR;
        hit_id_d  = '0;
        hit_vld_d = 1'b0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (cover_q[i]) begin
                color_d   = col1_q[i*COLOR_W +: COLOR_W];
                hit_id_d  = HIT_W'(i);
                hit_vld_d = 1'b1;
            end
        end
    end

    // Stage 2: registered composited result and frame tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            color_q   <= BG_COLOR;
            hit_id_q  <= '0;
            hit_vld_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            color_q   <= color_d;
            hit_id_q  <= hit_id_d;
            hit_vld_q <= hit_vld_d;
            tick_q    <= last1_q;
        end
    end

    assign color_out  = color_q;
    assign hit_id     = hit_id_q;
    assign hit_valid  = hit_vld_q;
    assign frame_tick = tick_q;

`ifdef SPRITE_LAYER_COLLIDE_EN
    logic [NUM_SPRITES-1:0] overlap_d;
    logic [NUM_SPRITES-1:0] pending_q;
    logic [NUM_SPRITES-1:0] collide_q;

    // Clearing the lowest set bit leaves something only when two or more sprites cover.
    assign overlap_d = ((cover_q & (cover_q - NUM_SPRITES'(1))) != '0) ? cover_q : '0;

    // Accumulate overlaps over the frame; publish on the tick, including the last pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            collide_q <= '0;
        end else if (last1_q) begin
            collide_q <= pending_q | overlap_d;
            pending_q <= '0;
        end else begin
            pending_q <= pending_q | overlap_d;
        end
    end

    assign collide_mask = collide_q;
`endif

endmodule
